// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one outstanding imem request
// at a time, buffers responses in a 2-entry FIFO and drops fetches made stale by a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_sel,
  input  logic [31:0] pc_target,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready
);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_pc_d    [2];
  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_instr_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;

  logic [31:0] target;
  logic        retire;
  logic        enq;
  logic        deq;
  logic        accept;
  logic [1:0]  count_after;

  always_comb begin
    target      = pc_target & 32'hFFFF_FFFC;
    retire      = (state_q == IDLE) | imem_rsp_valid;
    enq         = imem_rsp_valid & (state_q == WAIT) & ~pc_sel;
    if_valid    = (count_q != '0) & ~pc_sel;
    deq         = if_valid & if_ready;
    // A redirect empties the FIFO, so the space rule sees a count of zero.
    count_after = pc_sel ? '0 : count_q + {1'b0, enq} - {1'b0, deq};

    imem_req_valid = ~reset & retire & (count_after <= 2'd1);
    imem_req_addr  = pc_sel ? target : pc_q;
    accept         = imem_req_valid & imem_req_ready;

    if_pc    = fifo_pc_q[rd_ptr_q];
    if_instr = fifo_instr_q[rd_ptr_q];

    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_after;

    if (pc_sel) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (enq) begin
        fifo_pc_d[wr_ptr_q]    = req_pc_q;
        fifo_instr_d[wr_ptr_q] = imem_rsp_data;
        wr_ptr_d               = ~wr_ptr_q;
      end
      if (deq) begin
        rd_ptr_d = ~rd_ptr_q;
      end
    end

    if (accept) begin
      req_pc_d = imem_req_addr;
      pc_d     = imem_req_addr + 32'd4;
      state_d  = WAIT;
    end else if (pc_sel) begin
      pc_d    = target;
      state_d = retire ? IDLE : DRAIN;
    end else if ((state_q != IDLE) && imem_rsp_valid) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_pc_q[i]    <= fifo_pc_d[i];
        fifo_instr_q[i] <= fifo_instr_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based reference of fetch behaviour.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_sel;
  logic [31:0] pc_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_sel         (pc_sel),
    .pc_target      (pc_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: queue of buffered PCs, one outstanding memory transaction,
  // and the address the next fetch should use.
  logic [31:0] mq[$];
  bit          m_busy;
  bit          m_live;
  logic [31:0] m_addr;
  int          m_lat;
  int          lat_cfg;
  logic [31:0] exp_fetch;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_busy    = 1'b0;
    m_live    = 1'b0;
    m_lat     = 0;
    exp_fetch = RST_PC;
  endtask

  // One clock cycle: drive at the falling edge, check 1 time unit later, advance the model.
  task automatic cyc(input bit sel, input logic [31:0] tgt, input bit ifr, input bit mrdy);
    bit          rsp;
    bit          retire;
    bit          exp_ifv;
    bit          deq;
    bit          enq;
    bit          exp_rv;
    int          n;
    logic [31:0] exp_addr;
    @(negedge clk);
    rsp            = m_busy && (m_lat == 0);
    pc_sel         = sel;
    pc_target      = tgt;
    if_ready       = ifr;
    imem_req_ready = mrdy;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? instr_of(m_addr) : $urandom;
    #1;
    retire  = !m_busy || rsp;
    exp_ifv = (mq.size() != 0) && !sel;
    check_eq("if_valid", 32'(if_valid), 32'(exp_ifv));
    if (exp_ifv) begin
      check_eq("if_pc", if_pc, mq[0]);
      check_eq("if_instr", if_instr, instr_of(mq[0]));
    end
    deq      = exp_ifv && ifr;
    enq      = rsp && m_live && !sel;
    n        = sel ? 0 : int'(mq.size()) + int'(enq) - int'(deq);
    exp_rv   = retire && (n <= 1);
    exp_addr = sel ? {tgt[31:2], 2'b00} : exp_fetch;
    check_eq("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    check_eq("req_addr", imem_req_addr, exp_addr);

    if (sel) begin
      mq.delete();
    end else begin
      if (deq) void'(mq.pop_front());
      if (enq) mq.push_back(m_addr);
    end
    if (m_busy && !rsp) m_lat--;
    if (rsp) m_busy = 1'b0;
    if (exp_rv && mrdy) begin
      m_busy    = 1'b1;
      m_live    = 1'b1;
      m_addr    = exp_addr;
      m_lat     = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      exp_fetch = exp_addr + 32'd4;
    end else if (sel) begin
      exp_fetch = {tgt[31:2], 2'b00};
      m_live    = 1'b0;
    end
  endtask

  initial begin
    bit          found;
    bit          sel;
    logic [31:0] tgt;

    reset          = 1'b1;
    pc_sel         = 1'b0;
    pc_target      = '0;
    if_ready       = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    lat_cfg        = 0;
    model_reset();

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_req_addr", imem_req_addr, RST_PC);
    check_eq("rst_if_valid", 32'(if_valid), 32'd0);
    check_eq("rst_if_pc", if_pc, 32'd0);
    check_eq("rst_if_instr", if_instr, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;

    // Streaming with 1-cycle memory and no stalls.
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, '0, 1'b1, 1'b1);
      if (k < 3) begin
        check_eq("t1_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("t1_req_addr", imem_req_addr, 32'(4 * k));
      end
      if (k >= 2) begin
        check_eq("t1_if_valid", 32'(if_valid), 32'd1);
        check_eq("t1_if_pc", if_pc, 32'(4 * (k - 2)));
      end
    end

    // Decode stall fills the FIFO and stops fetching.
    for (int k = 0; k < 5; k++) cyc(1'b0, '0, 1'b0, 1'b1);
    check_eq("t2_stall_noreq", 32'(imem_req_valid), 32'd0);
    check_eq("t2_stall_full", 32'(if_valid), 32'd1);
    repeat (8) cyc(1'b0, '0, 1'b1, 1'b1);

    // Redirect while a request is outstanding: stale response dropped.
    lat_cfg = 2;
    found   = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      cyc(1'b0, '0, 1'b1, 1'b1);
      found = m_busy && (m_lat == 2);
    end
    check_eq("t3_accept", 32'(found), 32'd1);
    cyc(1'b1, 32'h0000_0100, 1'b1, 1'b1);
    check_eq("t3_sel_noreq", 32'(imem_req_valid), 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    check_eq("t3_drain_noreq", 32'(imem_req_valid), 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    check_eq("t3_tgt_valid", 32'(imem_req_valid), 32'd1);
    check_eq("t3_tgt_addr", imem_req_addr, 32'h0000_0100);
    lat_cfg = 0;
    repeat (6) cyc(1'b0, '0, 1'b1, 1'b1);

    // Redirect from IDLE with buffered instructions and a misaligned target.
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 10 && m_busy; k++) cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0203, 1'b0, 1'b1);
    check_eq("t4_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("t4_req_addr", imem_req_addr, 32'h0000_0200);
    check_eq("t4_if_valid", 32'(if_valid), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check_eq("t4_flushed", 32'(if_valid), 32'd0);
    check_eq("t4_next_addr", imem_req_addr, 32'h0000_0204);
    cyc(1'b0, '0, 1'b1, 1'b1);
    check_eq("t4_if_valid2", 32'(if_valid), 32'd1);
    check_eq("t4_if_pc", if_pc, 32'h0000_0200);

    // Redirect coinciding with a live response while the FIFO holds an entry.
    lat_cfg = 1;
    for (int k = 0; k < 12 && !(!m_busy && mq.size() == 2); k++) cyc(1'b0, '0, 1'b0, 1'b1);
    check_eq("t5_full", 32'(mq.size()), 32'd2);
    cyc(1'b0, '0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, 32'h0000_0300, 1'b0, 1'b1);
    check_eq("t5_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("t5_req_addr", imem_req_addr, 32'h0000_0300);
    check_eq("t5_if_valid", 32'(if_valid), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check_eq("t5_empty", 32'(if_valid), 32'd0);
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b1);

    // PC wrap-around at the top of the address space.
    lat_cfg = 0;
    for (int k = 0; k < 10 && m_busy; k++) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    check_eq("wrap_req_addr0", imem_req_addr, 32'hFFFF_FFFC);
    cyc(1'b0, '0, 1'b1, 1'b1);
    check_eq("wrap_req_addr1", imem_req_addr, 32'h0000_0000);
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b1);

    // Asynchronous reset during WAIT.
    lat_cfg = 1;
    found   = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      cyc(1'b0, '0, 1'b1, 1'b1);
      found = m_busy && (m_lat == 1);
    end
    check_eq("t7_accept", 32'(found), 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    #1 reset = 1'b1;
    #1;
    check_eq("t7_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("t7_rst_req_addr", imem_req_addr, RST_PC);
    check_eq("t7_rst_if_valid", 32'(if_valid), 32'd0);
    check_eq("t7_rst_if_pc", if_pc, 32'd0);
    model_reset();
    imem_rsp_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    cyc(1'b0, '0, 1'b1, 1'b1);
    check_eq("t7_restart_valid", 32'(imem_req_valid), 32'd1);
    check_eq("t7_restart_addr", imem_req_addr, RST_PC);

    // Random traffic.
    lat_cfg = -1;
    for (int k = 0; k < 4000; k++) begin
      sel = ($urandom_range(0, 99) < 8);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cyc(sel, tgt, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
